// File: rtl/div_seq_ctrl.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU with sign correction and flush cancel.
// Returns {remainder, quotient} with a one-cycle ready pulse.
//
//  state  | meaning
//  IDLE   | waiting for an accepted start request
//  BUSY   | 32 shift-subtract iterations, one quotient bit per cycle
//  DONE   | result valid, div_ready pulses unless annulled
module div_seq_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_div,
    input  logic        signed_div,
    input  logic [31:0] div_srca,
    input  logic [31:0] div_srcb,
    input  logic        annul,
    output logic        div_ready,
    output logic [63:0] div_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic [63:0] prev_q, prev_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        q_bit;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        abs_a  = (signed_div && div_srca[31]) ? (~div_srca + 32'd1) : div_srca;
        abs_b  = (signed_div && div_srcb[31]) ? (~div_srcb + 32'd1) : div_srcb;
        // rem < divisor always, so the shifted remainder fits 33 bits and the
        // difference, when taken, fits back into 32.
        rem_sh = {rem_q, dvd_q[31]};
        q_bit  = (rem_sh >= {1'b0, dvs_q});
        diff   = rem_sh[31:0] - dvs_q;
        rem_nx = q_bit ? diff : rem_sh[31:0];
        quo_nx = {dvd_q[30:0], q_bit};
        quo_fix = q_neg_q ? (~quo_nx + 32'd1) : quo_nx;
        rem_fix = r_neg_q ? (~rem_nx + 32'd1) : rem_nx;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        prev_d  = prev_q;
        case (state_q)
            S_IDLE: begin
                if (start_div && !annul) begin
                    if (div_srcb == 32'd0) begin
                        prev_d  = res_q;
                        res_d   = {div_srca, 32'hFFFF_FFFF};
                        state_d = S_DONE;
                    end else begin
                        dvd_d   = abs_a;
                        dvs_d   = abs_b;
                        q_neg_d = signed_div & (div_srca[31] ^ div_srcb[31]);
                        r_neg_d = signed_div & div_srca[31];
                        rem_d   = 32'd0;
                        cnt_d   = 5'd0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx;
                    dvd_d = quo_nx;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        prev_d  = res_q;
                        res_d   = {rem_fix, quo_fix};
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // A flushed result must not become architecturally visible.
                if (annul) begin
                    res_d = prev_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rem_q   <= 32'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= 5'd0;
            res_q   <= 64'd0;
            prev_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            prev_q  <= prev_d;
        end
    end

    assign div_ready  = (state_q == S_DONE) && !annul;
    assign busy       = (state_q != S_IDLE);
    assign div_result = res_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: a cycle-count model computes expected outputs with
// 64-bit arithmetic, checked every cycle, plus directed literal expectations.
module tb_div_seq_ctrl;

    logic        clk;
    logic        resetn;
    logic        start_div;
    logic        signed_div;
    logic [31:0] div_srca;
    logic [31:0] div_srcb;
    logic        annul;
    logic        div_ready;
    logic [63:0] div_result;
    logic        busy;

    int vec_cnt;
    int err_cnt;

    div_seq_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_div  (start_div),
        .signed_div (signed_div),
        .div_srca   (div_srca),
        .div_srcb   (div_srcb),
        .annul      (annul),
        .div_ready  (div_ready),
        .div_result (div_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from signed/unsigned 64-bit division.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: m_left counts cycles until the ready cycle (1 = ready cycle, 0 = idle).
    int          m_left;
    logic [63:0] m_res, m_prev, m_pend;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_res  <= 64'd0;
            m_prev <= 64'd0;
            m_pend <= 64'd0;
        end else if (m_left == 0) begin
            if (start_div && !annul) begin
                if (div_srcb == 32'd0) begin
                    m_left <= 1;
                    m_prev <= m_res;
                    m_res  <= ref_div(signed_div, div_srca, div_srcb);
                end else begin
                    m_left <= 33;
                    m_pend <= ref_div(signed_div, div_srca, div_srcb);
                end
            end
        end else if (annul) begin
            m_left <= 0;
            if (m_left == 1) m_res <= m_prev;
        end else begin
            if (m_left == 2) begin
                m_prev <= m_res;
                m_res  <= m_pend;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_ready", {63'd0, div_ready}, {63'd0, (m_left == 1) && !annul});
        chk("cyc_busy", {63'd0, busy}, {63'd0, m_left != 0});
        chk("cyc_result", div_result, m_res);
    end

    // Call at posedge+1; returns at posedge+1 in the cycle after ready.
    task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res, input int exp_edges);
        int   edges;
        logic seen;
        start_div  = 1'b1;
        signed_div = sg;
        div_srca   = a;
        div_srcb   = b;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (div_ready) seen = 1'b1;
            if (edges == 3) begin
                div_srca   = $urandom;
                div_srcb   = $urandom;
                signed_div = ~signed_div;
            end
        end
        start_div = 1'b0;
        chk({name, "_seen"}, {63'd0, seen}, 64'd1);
        chk({name, "_edges"}, 64'(edges), 64'(exp_edges));
        chk({name, "_result"}, div_result, exp_res);
        @(posedge clk);
        #1;
        chk({name, "_ready_low"}, {63'd0, div_ready}, 64'd0);
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        resetn     = 1'b0;
        start_div  = 1'b0;
        signed_div = 1'b0;
        div_srca   = 32'd0;
        div_srcb   = 32'd0;
        annul      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, div_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", div_result, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 33 edges from the request cycle to the ready cycle = 34-cycle stall.
        run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
        run_div("div_by0", 1'b1, 32'h0000_1234, 32'd0, 64'h00001234_FFFFFFFF, 1);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);

        // Annul at BUSY count 10.
        begin
            logic any_ready;
            any_ready  = 1'b0;
            start_div  = 1'b1;
            signed_div = 1'b0;
            div_srca   = 32'd1000;
            div_srcb   = 32'd3;
            repeat (11) begin
                @(posedge clk);
                #1;
                if (div_ready) any_ready = 1'b1;
            end
            annul     = 1'b1;
            start_div = 1'b0;
            @(posedge clk);
            #1;
            annul = 1'b0;
            if (div_ready) any_ready = 1'b1;
            chk("annul_busy_low", {63'd0, busy}, 64'd0);
            chk("annul_no_ready", {63'd0, any_ready}, 64'd0);
            chk("annul_result_kept", div_result, 64'h00000000_80000000);
        end
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        // Annul coinciding with DONE.
        begin
            start_div  = 1'b1;
            signed_div = 1'b0;
            div_srca   = 32'd50;
            div_srcb   = 32'd5;
            repeat (33) @(posedge clk);
            #1;
            annul     = 1'b1;
            start_div = 1'b0;
            #1;
            chk("annul_done_ready", {63'd0, div_ready}, 64'd0);
            @(posedge clk);
            #1;
            annul = 1'b0;
            chk("annul_done_busy", {63'd0, busy}, 64'd0);
            chk("annul_done_result", div_result, 64'h00000002_0000000E);
        end

        // Asynchronous reset mid-BUSY, away from any clock edge.
        begin
            start_div  = 1'b1;
            signed_div = 1'b0;
            div_srca   = 32'd1000;
            div_srcb   = 32'd3;
            repeat (5) @(posedge clk);
            #2;
            resetn = 1'b0;
            #1;
            chk("async_rst_busy", {63'd0, busy}, 64'd0);
            chk("async_rst_ready", {63'd0, div_ready}, 64'd0);
            chk("async_rst_result", div_result, 64'd0);
            start_div = 1'b0;
            repeat (2) @(posedge clk);
            #3;
            resetn = 1'b1;
            @(posedge clk);
            #1;
            chk("post_rst_idle", {63'd0, busy}, 64'd0);
        end

        run_div("b2b_first", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33);
        run_div("b2b_second", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
